add32_unit: RTL and testbench
=============================

Name: add32_unit

Overview:
- 32-bit two's-complement adder used for PC+4 and branch-target arithmetic in the single-cycle CPU.
- Provides a zero-latency combinational sum `out` for the datapath.
- Also provides a one-cycle registered copy of the sum with status flags (carry, overflow, zero, negative) under a valid strobe, for the debug and flag logic.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; tie to 0 for a plain add.
- in_valid  input  1  operands valid this cycle; when high, the registered result and flags are captured.
- out  output  WIDTH  combinational sum, (a + b + cin) mod 2^WIDTH.
- out_q  output  WIDTH  registered sum.
- out_valid  output  1  high for one cycle after a cycle in which in_valid was high.
- carry_q  output  1  registered carry-out of bit WIDTH-1.
- ovf_q  output  1  registered signed overflow: operands have the same sign and the result sign differs.
- zero_q  output  1  registered; high when the sum is all zeros.
- neg_q  output  1  registered; equals the sum's bit WIDTH-1.

Behaviour:
- `out` is purely combinational with zero latency. Wrap-around is modulo 2^WIDTH; the carry is discarded on `out`.
- Sum is computed at WIDTH+1 bits: {carry, sum} = a + b + cin.
- Registered path, on each rising edge of clk:
  - rst_n == 0: out_q = 0, carry_q = 0, ovf_q = 0, zero_q = 0, neg_q = 0, out_valid = 0. Reset overrides in_valid.
  - rst_n == 1 and in_valid == 1: capture sum, carry, ovf, zero and neg of the current inputs; out_valid = 1.
  - rst_n == 1 and in_valid == 0: out_q and all flags hold their previous values; out_valid = 0.
- Latency of the registered path: exactly 1 cycle. Back-to-back in_valid is accepted every cycle, with no backpressure.
- Reset asserted mid-stream clears everything on that edge; the result being captured on that edge is lost.
- `out` is unaffected by reset and tracks the inputs at all times.
- Overflow: ovf = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]), where b_eff is the operand actually added.
- No X propagation from the registers after the first reset edge.

Optional Feature:
- Macro ADD32_SUB_EN.
- When defined:
  - Extra input port `sub` (1 bit) is present.
  - With sub == 1, b_eff = ~b and the effective carry-in = 1 (cin is ignored), so out = a - b mod 2^WIDTH.
  - carry_q then means "no borrow" (carry = 1 when a >= b unsigned).
  - ovf follows the formula above using b_eff.
  - With sub == 0, behaviour is identical to the plain adder.
- When not defined:
  - Port `sub` does not exist.
  - b_eff = b; the block always adds.

Test Plan:
- Reset: hold rst_n = 0 for 2 edges with in_valid = 1 and a = 5, b = 6 -> out_q = 0, all flags 0, out_valid = 0; `out` = 11 throughout.
- Basic add: a = 0x00000033, b = 4, cin = 0 -> out = 0x00000037 immediately; with in_valid pulsed, the next edge gives out_q = 0x37, out_valid = 1, carry/ovf/zero/neg all 0.
- Wrap: a = 0xFFFFFFFF, b = 4 -> out = 0x00000003; registered result gives carry_q = 1, ovf_q = 0, neg_q = 0, zero_q = 0.
- Signed overflow and zero:
  - a = 0x7FFFFFFF, b = 1 -> out_q = 0x80000000, ovf_q = 1, neg_q = 1, carry_q = 0.
  - a = 0xFFFFFFFF, b = 1 -> out_q = 0, zero_q = 1, carry_q = 1.
- Hold and back-to-back:
  - in_valid high for cycles 1 and 2 with sums 10 then 20, low at cycle 3 -> out_q = 10, then 20, then holds 20; out_valid = 1, 1, 0.
- Subtract (ADD32_SUB_EN only): sub = 1, a = 3, b = 5 -> out = 0xFFFFFFFE, carry_q = 0, neg_q = 1; with a = 5, b = 3 -> out = 2, carry_q = 1.

Source files
------------

// File: rtl/add32_unit.sv
// add32_unit: 32-bit two's-complement adder for PC+4 and branch-target math.
// Provides a zero-latency combinational sum plus a one-cycle registered copy
// with carry/overflow/zero/negative flags captured under in_valid.
// Optional macro ADD32_SUB_EN adds a `sub` input selecting a - b.
module add32_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef ADD32_SUB_EN
   input  logic             sub,
`endif
   input  logic             in_valid,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q,
   output logic             out_valid,
   output logic             carry_q,
   output logic             ovf_q,
   output logic             zero_q,
   output logic             neg_q
);

   // Signed overflow: same-sign operands whose result sign flips.
   function automatic logic calc_ovf(input logic sa, input logic sb, input logic sr);
      return (sa == sb) && (sr != sa);
   endfunction

   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH-1:0] out_d;
   logic             out_valid_d;
   logic             carry_d;
   logic             ovf_d;
   logic             zero_d;
   logic             neg_d;

   // Operand selection and full-width (carry-preserving) addition.
   always_comb begin
`ifdef ADD32_SUB_EN
      b_eff   = sub ? ~b : b;
      cin_eff = sub ? 1'b1 : cin;
`else
      b_eff   = b;
      cin_eff = cin;
`endif
      sum_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};
   end

   assign out = sum_ext[WIDTH-1:0];

   // Next-state: capture sum and flags on in_valid, otherwise hold.
   always_comb begin
      out_d       = out_q;
      carry_d     = carry_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      neg_d       = neg_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         out_d       = sum_ext[WIDTH-1:0];
         carry_d     = sum_ext[WIDTH];
         ovf_d       = calc_ovf(a[WIDTH-1], b_eff[WIDTH-1], sum_ext[WIDTH-1]);
         zero_d      = (sum_ext[WIDTH-1:0] == '0);
         neg_d       = sum_ext[WIDTH-1];
         out_valid_d = 1'b1;
      end
   end

   // Result/flag registers; reset clears everything and wins over in_valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q     <= '0;
         carry_q   <= 1'b0;
         ovf_q     <= 1'b0;
         zero_q    <= 1'b0;
         neg_q     <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_q     <= out_d;
         carry_q   <= carry_d;
         ovf_q     <= ovf_d;
         zero_q    <= zero_d;
         neg_q     <= neg_d;
         out_valid <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_add32_unit.sv
// Directed self-checking bench for add32_unit (optionally with ADD32_SUB_EN).
module tb_add32_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic        sub;
   logic        in_valid;
   logic [31:0] out;
   logic [31:0] out_q;
   logic        out_valid;
   logic        carry_q;
   logic        ovf_q;
   logic        zero_q;
   logic        neg_q;

   int errors = 0;
   int checks = 0;

   add32_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef ADD32_SUB_EN
      .sub       (sub),
`endif
      .in_valid  (in_valid),
      .out       (out),
      .out_q     (out_q),
      .out_valid (out_valid),
      .carry_q   (carry_q),
      .ovf_q     (ovf_q),
      .zero_q    (zero_q),
      .neg_q     (neg_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Flags packed as {carry, ovf, zero, neg}.
   function automatic logic [31:0] flags();
      return {28'd0, carry_q, ovf_q, zero_q, neg_q};
   endfunction

   initial begin
      rst_n = 1'b0; in_valid = 1'b1; a = 32'd5; b = 32'd6; cin = 1'b0; sub = 1'b0;
      #1;
      chk("rst_out_comb", out, 32'd11);
      step();
      chk("rst1_out_q", out_q, 32'd0);
      chk("rst1_valid", {31'd0, out_valid}, 32'd0);
      chk("rst1_flags", flags(), 32'h0);
      chk("rst1_out_comb", out, 32'd11);
      step();
      chk("rst2_out_q", out_q, 32'd0);
      chk("rst2_valid", {31'd0, out_valid}, 32'd0);
      chk("rst2_flags", flags(), 32'h0);
      chk("rst2_out_comb", out, 32'd11);

      rst_n = 1'b1; a = 32'h33; b = 32'd4; in_valid = 1'b1;
      #1;
      chk("basic_comb", out, 32'h37);
      step();
      chk("basic_out_q", out_q, 32'h37);
      chk("basic_valid", {31'd0, out_valid}, 32'd1);
      chk("basic_flags", flags(), 32'h0);

      a = 32'hFFFF_FFFF; b = 32'd4;
      #1;
      chk("wrap_comb", out, 32'd3);
      step();
      chk("wrap_out_q", out_q, 32'd3);
      chk("wrap_flags", flags(), 32'h8);

      a = 32'h7FFF_FFFF; b = 32'd1;
      step();
      chk("povf_out_q", out_q, 32'h8000_0000);
      chk("povf_flags", flags(), 32'h5);

      a = 32'hFFFF_FFFF; b = 32'd1;
      step();
      chk("zero_out_q", out_q, 32'h0);
      chk("zero_flags", flags(), 32'hA);

      a = 32'h8000_0000; b = 32'h8000_0000;
      step();
      chk("novf_out_q", out_q, 32'h0);
      chk("novf_flags", flags(), 32'hE);

      a = 32'd1; b = 32'd2; cin = 1'b1;
      #1;
      chk("cin_comb", out, 32'd4);
      step();
      chk("cin_out_q", out_q, 32'd4);
      cin = 1'b0;

      a = 32'd4; b = 32'd6;
      step();
      chk("b2b1_out_q", out_q, 32'd10);
      chk("b2b1_valid", {31'd0, out_valid}, 32'd1);
      a = 32'd15; b = 32'd5;
      step();
      chk("b2b2_out_q", out_q, 32'd20);
      chk("b2b2_valid", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b0; a = 32'd1; b = 32'd1;
      step();
      chk("hold_out_q", out_q, 32'd20);
      chk("hold_valid", {31'd0, out_valid}, 32'd0);
      chk("hold_flags", flags(), 32'h0);
      chk("hold_comb", out, 32'd2);
      a = 32'hFFFF_FFFF; b = 32'd4;
      step();
      chk("hold2_out_q", out_q, 32'd20);

      in_valid = 1'b1; a = 32'h7FFF_FFFF; b = 32'd1; rst_n = 1'b0;
      step();
      chk("midrst_out_q", out_q, 32'd0);
      chk("midrst_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_flags", flags(), 32'h0);
      chk("midrst_comb", out, 32'h8000_0000);
      rst_n = 1'b1;

`ifdef ADD32_SUB_EN
      sub = 1'b1; a = 32'd3; b = 32'd5; cin = 1'b0;
      #1;
      chk("sub1_comb", out, 32'hFFFF_FFFE);
      step();
      chk("sub1_out_q", out_q, 32'hFFFF_FFFE);
      chk("sub1_flags", flags(), 32'h1);
      a = 32'd5; b = 32'd3; cin = 1'b1;
      #1;
      chk("sub2_comb", out, 32'd2);
      step();
      chk("sub2_out_q", out_q, 32'd2);
      chk("sub2_flags", flags(), 32'h8);
      a = 32'h8000_0000; b = 32'd1; cin = 1'b0;
      step();
      chk("sub3_out_q", out_q, 32'h7FFF_FFFF);
      chk("sub3_flags", flags(), 32'hC);
      sub = 1'b0; a = 32'd3; b = 32'd5;
      step();
      chk("sub0_out_q", out_q, 32'd8);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
